// File: rtl/levit_stage_sequencer.sv
// levit_stage_sequencer: chains N_STAGE compute stages, overlapping frames, sticky error, frame count.
// Optional per-stage watchdog enabled by defining LEVIT_SEQ_WATCHDOG_EN.
module levit_stage_sequencer #(
  parameter int N_STAGE = 11,
  parameter int FRAME_W = 8,
  parameter int WDOG_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       start_ready,
  input  logic [N_STAGE-1:0]         stage_end,
  output logic [N_STAGE-1:0]         stage_en,
  output logic                       busy,
  output logic                       done,
  output logic [FRAME_W-1:0]         frame_cnt,
  input  logic [WDOG_W-1:0]          wdog_limit,
  input  logic                       err_clr,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [$clog2(N_STAGE)-1:0] err_stage
);
  localparam int SW = $clog2(N_STAGE);
  logic [N_STAGE-1:0] en_q, en_d, pend_q, pend_d, gap_q, gap_d;
  logic [N_STAGE-1:0] acc, pred, ovf, wto, hit;
  logic               done_q, done_d, err_q, err_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [1:0]         code_q, code_d;
  logic [SW-1:0]      stg_q, stg_d;
  assign start_ready = !en_q[0] && !pend_q[0] && !err_q;
  assign acc         = stage_end & en_q & {N_STAGE{!err_q}};
`ifdef LEVIT_SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] cnt_q [N_STAGE];
  logic [WDOG_W-1:0] cnt_d [N_STAGE];
  always_comb begin
    for (int i = 0; i < N_STAGE; i++) begin
      cnt_d[i] = (en_q[i] && !acc[i]) ? cnt_q[i] + WDOG_W'(1) : '0;
      wto[i]   = en_q[i] && !acc[i] && (wdog_limit != '0) &&
                 ({1'b0, cnt_q[i]} + (WDOG_W+1)'(1) >= {1'b0, wdog_limit});
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_STAGE; i++) cnt_q[i] <= rst ? '0 : cnt_d[i];
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^wdog_limit;
  assign wto = '0;
`endif
  // A stage that ends while another frame waits (or arrives) drops its enable for one gap cycle.
  always_comb begin
    pred    = acc << 1;
    pred[0] = start && start_ready;
    for (int i = 0; i < N_STAGE; i++) begin
      ovf[i]    = pred[i] && pend_q[i] && !acc[i];
      en_d[i]   = acc[i] ? 1'b0 : (en_q[i] || gap_q[i] || pred[i]);
      gap_d[i]  = acc[i] && (pend_q[i] || pred[i]);
      pend_d[i] = acc[i] ? (pend_q[i] && pred[i])
                         : (pend_q[i] || (pred[i] && (en_q[i] || gap_q[i])));
    end
    hit    = ovf | wto;
    err_d  = err_q && !err_clr;
    code_d = err_clr ? 2'b00 : code_q;
    stg_d  = err_clr ? '0 : stg_q;
    for (int i = N_STAGE - 1; i >= 0; i--) begin
      if (hit[i]) begin
        stg_d  = SW'(i);
        code_d = ovf[i] ? 2'b01 : 2'b10;
      end
    end
    if (|hit) begin
      err_d  = 1'b1;
      en_d   = '0;
      pend_d = '0;
      gap_d  = '0;
    end
    done_d  = acc[N_STAGE-1];
    frame_d = frame_q + FRAME_W'(acc[N_STAGE-1]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= '0;
      pend_q  <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      frame_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      stg_q   <= '0;
    end else begin
      en_q    <= en_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      code_q  <= code_d;
      stg_q   <= stg_d;
    end
  end
  assign stage_en  = en_q;
  assign busy      = |(en_q | pend_q | gap_q);
  assign done      = done_q;
  assign frame_cnt = frame_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign err_stage = stg_q;
endmodule

// File: tb/tb_levit_stage_sequencer.sv
// tb_levit_stage_sequencer: directed + random stimulus against a frame-occupancy reference model.
module tb_levit_stage_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start_ready;
  logic [2:0] stage_end = '0;
  logic [2:0] stage_en;
  logic       busy, done;
  logic [1:0] frame_cnt;
  logic [7:0] wdog_limit = '0;
  logic       err_clr = 1'b0;
  logic       err;
  logic [1:0] err_code;
  logic [1:0] err_stage;
  int checks = 0;
  int errors = 0;
  int occ [3];
  bit gap [3];
  int wd  [3];
  bit m_err, m_done;
  int m_code, m_stg, m_frame;
  int ndone;

  levit_stage_sequencer #(.N_STAGE(3), .FRAME_W(2), .WDOG_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .stage_end(stage_end), .stage_en(stage_en), .busy(busy), .done(done),
    .frame_cnt(frame_cnt), .wdog_limit(wdog_limit), .err_clr(err_clr),
    .err(err), .err_code(err_code), .err_stage(err_stage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each stage holds 0..2 frames (running + one waiting); a departure with frames left costs a gap cycle.
  task automatic model_update();
    bit acc [3];
    bit arr [3];
    bit wdog_on;
    int hit, hcode;
`ifdef LEVIT_SEQ_WATCHDOG_EN
    wdog_on = (wdog_limit != 0);
`else
    wdog_on = 1'b0;
`endif
    if (rst) begin
      for (int i = 0; i < 3; i++) begin occ[i] = 0; gap[i] = 0; wd[i] = 0; end
      m_err = 0; m_done = 0; m_code = 0; m_stg = 0; m_frame = 0;
      return;
    end
    for (int i = 0; i < 3; i++) acc[i] = stage_end[i] && occ[i] > 0 && !gap[i] && !m_err;
    arr[0] = start && occ[0] == 0 && !m_err;
    arr[1] = acc[0];
    arr[2] = acc[1];
    m_done = acc[2];
    if (acc[2]) m_frame = (m_frame + 1) % 4;
    hit = -1;
    hcode = 0;
    for (int i = 2; i >= 0; i--) begin
      if (arr[i] && occ[i] == 2 && !acc[i]) begin hit = i; hcode = 1; end
      else if (wdog_on && occ[i] > 0 && !gap[i] && !acc[i] && wd[i] + 1 >= int'(wdog_limit)) begin
        hit = i; hcode = 2;
      end
    end
    if (hit >= 0) begin
      m_err = 1; m_code = hcode; m_stg = hit;
      for (int i = 0; i < 3; i++) begin occ[i] = 0; gap[i] = 0; wd[i] = 0; end
    end else begin
      if (err_clr) begin m_err = 0; m_code = 0; m_stg = 0; end
      for (int i = 0; i < 3; i++) begin
        wd[i]  = (occ[i] > 0 && !gap[i] && !acc[i]) ? wd[i] + 1 : 0;
        gap[i] = acc[i] && (occ[i] - int'(acc[i]) + int'(arr[i])) > 0;
        occ[i] = occ[i] - int'(acc[i]) + int'(arr[i]);
      end
    end
  endtask

  task automatic step();
    logic [2:0] e;
    model_update();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) e[i] = occ[i] > 0 && !gap[i];
    chk("stage_en", 32'(stage_en), 32'(e));
    chk("busy", 32'(busy), 32'(occ[0] > 0 || occ[1] > 0 || occ[2] > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
    chk("err", 32'(err), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("err_stage", 32'(err_stage), 32'(m_stg));
    chk("start_ready", 32'(start_ready), 32'(occ[0] == 0 && !m_err));
    if (done) ndone++;
  endtask

  task automatic drive(input bit s, input logic [2:0] e, input bit c, input bit r);
    start = s; stage_end = e; err_clr = c; rst = r;
    step();
    start = 0; stage_end = '0; err_clr = 0; rst = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 3'b000, 0, 0);
  endtask

  task automatic do_reset();
    drive(0, 3'b000, 0, 1);
    drive(0, 3'b000, 0, 1);
  endtask

  initial begin
    do_reset();
    chk("reset_en", 32'(stage_en), 0);
    chk("reset_ready", 32'(start_ready), 1);
    // single frame through three stages
    drive(1, 3'b000, 0, 0);
    chk("t1_en", 32'(stage_en), 32'h1);
    idle(2);
    drive(0, 3'b001, 0, 0);
    chk("t4_en", 32'(stage_en), 32'h2);
    idle(2);
    drive(0, 3'b010, 0, 0);
    chk("t7_en", 32'(stage_en), 32'h4);
    idle(2);
    drive(0, 3'b100, 0, 0);
    chk("t10_en", 32'(stage_en), 0);
    chk("t10_done", 32'(done), 1);
    chk("t10_frame", 32'(frame_cnt), 1);
    // four back-to-back frames, frame counter wraps
    do_reset();
    ndone = 0;
    for (int f = 0; f < 4; f++) begin
      drive(1, 3'b000, 0, 0);
      drive(0, 3'b001, 0, 0);
      drive(0, 3'b010, 0, 0);
      drive(0, 3'b100, 0, 0);
    end
    idle(2);
    chk("four_done", 32'(ndone), 4);
    chk("four_frame", 32'(frame_cnt), 0);
    // frame overlap: second frame waits on stage1, restarts after a gap
    do_reset();
    drive(1, 3'b000, 0, 0);
    drive(0, 3'b001, 0, 0);
    drive(1, 3'b000, 0, 0);
    drive(0, 3'b001, 0, 0);
    chk("ovl_busy", 32'(busy), 1);
    drive(0, 3'b010, 0, 0);
    chk("ovl_gap", 32'(stage_en[1]), 0);
    idle(1);
    chk("ovl_restart", 32'(stage_en[1]), 1);
    chk("ovl_no_err", 32'(err), 0);
    idle(2);
    // third predecessor end while stage1 already holds a waiting frame
    do_reset();
    drive(1, 3'b000, 0, 0);
    drive(0, 3'b001, 0, 0);
    drive(1, 3'b000, 0, 0);
    drive(0, 3'b001, 0, 0);
    drive(1, 3'b000, 0, 0);
    drive(0, 3'b001, 0, 0);
    chk("ovf_err", 32'(err), 1);
    chk("ovf_code", 32'(err_code), 1);
    chk("ovf_stage", 32'(err_stage), 1);
    chk("ovf_en", 32'(stage_en), 0);
    drive(1, 3'b111, 0, 0);
    chk("ovf_ignored", 32'(stage_en), 0);
    drive(0, 3'b000, 1, 0);
    chk("clr_err", 32'(err), 0);
    chk("clr_ready", 32'(start_ready), 1);
    // watchdog
    do_reset();
    wdog_limit = 8'd5;
    drive(1, 3'b000, 0, 0);
    idle(5);
`ifdef LEVIT_SEQ_WATCHDOG_EN
    chk("wdog_err", 32'(err), 1);
    chk("wdog_code", 32'(err_code), 2);
    chk("wdog_stage", 32'(err_stage), 0);
    do_reset();
    wdog_limit = 8'd0;
    drive(1, 3'b000, 0, 0);
    idle(20);
    chk("wdog_off", 32'(err), 0);
`else
    idle(10);
    chk("wdog_ignored", 32'(err), 0);
`endif
    // reset mid-stage1 overrides a same-cycle stage_end
    do_reset();
    wdog_limit = 8'd0;
    drive(1, 3'b000, 0, 0);
    drive(0, 3'b001, 0, 0);
    idle(1);
    drive(0, 3'b010, 0, 1);
    chk("rst_en", 32'(stage_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_frame", 32'(frame_cnt), 0);
    chk("rst_ready", 32'(start_ready), 1);
    // random traffic
    do_reset();
`ifdef LEVIT_SEQ_WATCHDOG_EN
    wdog_limit = 8'd20;
`else
    wdog_limit = 8'($urandom_range(0, 255));
`endif
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 1) == 1,
            {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0},
            $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
